// File: rtl/grf_pkg.sv
// Shared definitions for the grf write-port arbiter slice.
package grf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // IDLE: MD buffer empty, PEND: buffered MD write waiting for the port,
  // FORCE: buffered MD write owns the port and WB is held for one cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // One-hot mask selecting a single register of the file.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bundle of the WB request, MD handshake and grf write-port signals.
interface grf_write_arbiter_if #(parameter int DATA_W = 32);
  import grf_pkg::*;

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic [DATA_W-1:0]     wb_pc;
  logic                  stall_wb;

  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_reg;
  logic [DATA_W-1:0]     md_data;
  logic [DATA_W-1:0]     md_pc;
  logic                  md_issue;
  logic [REG_ADDR_W-1:0] md_issue_reg;

  logic                  grf_we;
  logic [REG_ADDR_W-1:0] grf_reg;
  logic [DATA_W-1:0]     grf_data;
  logic [DATA_W-1:0]     grf_pc;
  logic [NUM_REGS-1:0]   busy_mask;

  // Requester / register-file side.
  modport master (
    output wb_we, wb_reg, wb_data, wb_pc,
    output md_valid, md_reg, md_data, md_pc, md_issue, md_issue_reg,
    input  stall_wb, md_ready, grf_we, grf_reg, grf_data, grf_pc, busy_mask
  );

  // Arbiter side.
  modport slave (
    input  wb_we, wb_reg, wb_data, wb_pc,
    input  md_valid, md_reg, md_data, md_pc, md_issue, md_issue_reg,
    output stall_wb, md_ready, grf_we, grf_reg, grf_data, grf_pc, busy_mask
  );

endinterface

// File: rtl/grf_write_arbiter_md_write_buffer.sv
// One-entry holding register for an MD result waiting for the grf port.
module md_write_buffer
  import grf_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  drain,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W-1:0]     in_pc,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] buf_reg,
  output logic [DATA_W-1:0]     buf_data,
  output logic [DATA_W-1:0]     buf_pc
);

  // Capture on load, release on drain; load wins since it only occurs when empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid    <= 1'b0;
      buf_reg  <= ZERO_REG;
      buf_data <= '0;
      buf_pc   <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      buf_reg  <= in_reg;
      buf_data <= in_data;
      buf_pc   <= in_pc;
    end else if (drain) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Shares the single grf write port between WB (priority) and the MD unit,
// tracks outstanding MD destinations and stalls WB when MD starves.
module grf_write_arbiter
  import grf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input logic                clk,
  input logic                reset,
  grf_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t            state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
  logic [NUM_REGS-1:0]   busy, busy_nxt;
  logic                  port_free;
  logic                  load;
  logic                  drain;
  logic                  buf_valid;
  logic [REG_ADDR_W-1:0] buf_reg;
  logic [DATA_W-1:0]     buf_data;
  logic [DATA_W-1:0]     buf_pc;

  // A WB write to $0 never reaches the file, so it leaves the port free.
  assign port_free     = !bus.wb_we || (bus.wb_reg == ZERO_REG);
  assign load          = bus.md_valid && (state == IDLE);
  assign drain         = buf_valid && ((state == FORCE) || ((state == PEND) && port_free));
  assign bus.md_ready  = (state == IDLE);
  assign bus.stall_wb  = (state == FORCE);
  assign bus.busy_mask = busy;

  md_write_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .drain    (drain),
    .in_reg   (bus.md_reg),
    .in_data  (bus.md_data),
    .in_pc    (bus.md_pc),
    .valid    (buf_valid),
    .buf_reg  (buf_reg),
    .buf_data (buf_data),
    .buf_pc   (buf_pc)
  );

  // Port mux: drain the MD buffer when it owns the port, else pass WB through.
  always_comb begin
    bus.grf_we   = bus.wb_we && (bus.wb_reg != ZERO_REG);
    bus.grf_reg  = bus.wb_reg;
    bus.grf_data = bus.wb_data;
    bus.grf_pc   = bus.wb_pc;
    if (drain) begin
      bus.grf_we   = (buf_reg != ZERO_REG);
      bus.grf_reg  = buf_reg;
      bus.grf_data = buf_data;
      bus.grf_pc   = buf_pc;
    end
    if (!reset) begin
      bus.grf_we = 1'b0;
    end
  end

  // Next state and starvation counter.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt    = PEND;
          wait_cnt_nxt = '0;
        end
      end
      PEND: begin
        if (port_free) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt    = FORCE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      FORCE: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Busy scoreboard: clear on drain, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (drain) begin
      busy_nxt = busy_nxt & ~reg_bit(buf_reg);
    end
    if (bus.md_issue && (bus.md_issue_reg != ZERO_REG)) begin
      busy_nxt = busy_nxt | reg_bit(bus.md_issue_reg);
    end
  end

  // State, counter and scoreboard registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      busy     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Scoreboard bench: a behavioural model predicts grf writes into a queue and
// per-cycle control outputs; a negedge monitor compares against the DUT.
module tb_grf_write_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int DATA_W       = 32;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] p;
  } wr_t;

  logic clk;
  logic reset;

  grf_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

  grf_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  wr_t exp_q[$];

  // Model state: at most one pending MD write and how long it has been blocked.
  bit          m_pend = 0;
  logic [4:0]  m_reg  = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pc   = '0;
  int          m_blocked = 0;
  logic [31:0] m_busy = '0;
  bit          state_known = 0;
  bit          running = 0;
  bit          have_next = 0;

  bit          n_pend;
  logic [4:0]  n_reg;
  logic [31:0] n_data;
  logic [31:0] n_pc;
  int          n_blocked;
  logic [31:0] n_busy;
  bit          n_known;

  bit          exp_stall;
  bit          exp_ready;
  logic [31:0] exp_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one cycle of inputs and predicts that cycle's behaviour.
  task automatic applyStimulus(input bit rst, input bit we, input logic [4:0] wreg,
                               input logic [31:0] wdata, input logic [31:0] wpc,
                               input bit mv, input logic [4:0] mreg,
                               input logic [31:0] mdata, input logic [31:0] mpc,
                               input bit iss, input logic [4:0] ireg);
    bit  drained;
    bit  pfree;
    wr_t w;
    @(posedge clk);
    if (have_next) begin
      m_pend = n_pend; m_reg = n_reg; m_data = n_data; m_pc = n_pc;
      m_blocked = n_blocked; m_busy = n_busy; state_known = n_known;
    end
    #1;
    reset = rst;
    bus.wb_we = we; bus.wb_reg = wreg; bus.wb_data = wdata; bus.wb_pc = wpc;
    bus.md_valid = mv; bus.md_reg = mreg; bus.md_data = mdata; bus.md_pc = mpc;
    bus.md_issue = iss; bus.md_issue_reg = ireg;

    exp_ready = !m_pend;
    exp_stall = m_pend && (m_blocked == STARVE_LIMIT);
    exp_busy  = m_busy;
    n_pend = m_pend; n_reg = m_reg; n_data = m_data; n_pc = m_pc;
    n_blocked = m_blocked; n_busy = m_busy; n_known = state_known;

    if (!rst) begin
      n_pend = 0; n_blocked = 0; n_busy = '0; n_known = 1;
    end else begin
      pfree   = !we || (wreg == 5'd0);
      drained = 0;
      if (m_pend) begin
        if (exp_stall || pfree) begin
          drained = 1;
          if (m_reg != 5'd0) begin
            w.r = m_reg; w.d = m_data; w.p = m_pc;
            exp_q.push_back(w);
          end
        end else begin
          n_blocked = m_blocked + 1;
        end
      end
      if (!drained && we && wreg != 5'd0) begin
        w.r = wreg; w.d = wdata; w.p = wpc;
        exp_q.push_back(w);
      end
      if (drained) begin
        n_pend = 0; n_blocked = 0;
        n_busy[m_reg] = 1'b0;
      end
      if (!m_pend && mv) begin
        n_pend = 1; n_reg = mreg; n_data = mdata; n_pc = mpc; n_blocked = 0;
      end
      if (iss && ireg != 5'd0) n_busy[ireg] = 1'b1;
    end
    have_next = 1;
    running   = 1;
    @(negedge clk);
  endtask

  // Monitor: pops an expected write whenever the DUT writes the grf.
  always @(negedge clk) begin
    wr_t w;
    if (running) begin
      checks++;
      if (bus.grf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL grf_write actual=reg%0d required=no_write", bus.grf_reg);
        end else begin
          w = exp_q.pop_front();
          if (bus.grf_reg !== w.r || bus.grf_data !== w.d || bus.grf_pc !== w.p) begin
            errors++;
            $display("[TB] FAIL grf_write actual=%0d/%0h/%0h required=%0d/%0h/%0h",
                     bus.grf_reg, bus.grf_data, bus.grf_pc, w.r, w.d, w.p);
          end
        end
      end else if (exp_q.size() != 0 || bus.grf_we !== 1'b0) begin
        w = exp_q.size() != 0 ? exp_q.pop_front() : '{5'd0, 32'd0, 32'd0};
        errors++;
        $display("[TB] FAIL grf_write actual=we_%b required=reg%0d", bus.grf_we, w.r);
      end
      if (state_known) begin
        checkOutput("stall_wb", {31'd0, bus.stall_wb}, {31'd0, exp_stall});
        checkOutput("md_ready", {31'd0, bus.md_ready}, {31'd0, exp_ready});
        checkOutput("busy_mask", bus.busy_mask, exp_busy);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.wb_we = 0; bus.wb_reg = '0; bus.wb_data = '0; bus.wb_pc = '0;
    bus.md_valid = 0; bus.md_reg = '0; bus.md_data = '0; bus.md_pc = '0;
    bus.md_issue = 0; bus.md_issue_reg = '0;

    // Reset held two edges with a live WB request.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 5'd5, 32'h55, 32'h500, 0, 0, 0, 0, 0, 0);
      checkOutput("reset_grf_we", {31'd0, bus.grf_we}, 32'd0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_reset_busy", bus.busy_mask, 32'd0);
    checkOutput("post_reset_ready", {31'd0, bus.md_ready}, 32'd1);
    checkOutput("post_reset_stall", {31'd0, bus.stall_wb}, 32'd0);

    // WB pass-through, and a WB write to $0.
    applyStimulus(1, 1, 5'd10, 32'd16, 32'h12345678, 0, 0, 0, 0, 0, 0);
    checkOutput("pass_we", {31'd0, bus.grf_we}, 32'd1);
    checkOutput("pass_reg", {27'd0, bus.grf_reg}, 32'd10);
    checkOutput("pass_data", bus.grf_data, 32'd16);
    checkOutput("pass_pc", bus.grf_pc, 32'h12345678);
    applyStimulus(1, 1, 5'd0, 32'd16, 32'h12345678, 0, 0, 0, 0, 0, 0);
    checkOutput("pass_r0_we", {31'd0, bus.grf_we}, 32'd0);

    // MD write on an idle port.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd8);
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd8, 32'hDEADBEEF, 32'h3000, 0, 0);
    checkOutput("md_busy_set", {31'd0, bus.busy_mask[8]}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("md_we", {31'd0, bus.grf_we}, 32'd1);
    checkOutput("md_reg", {27'd0, bus.grf_reg}, 32'd8);
    checkOutput("md_data", bus.grf_data, 32'hDEADBEEF);
    checkOutput("md_ready_low", {31'd0, bus.md_ready}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("md_busy_clr", {31'd0, bus.busy_mask[8]}, 32'd0);
    checkOutput("md_ready_high", {31'd0, bus.md_ready}, 32'd1);

    // Starvation: WB writes $3 every cycle while MD waits with $9.
    applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 1, 5'd9, 32'h99, 32'h900, 1, 5'd9);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
      checkOutput("starve_blocked_reg", {27'd0, bus.grf_reg}, 32'd3);
    end
    applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_stall", {31'd0, bus.stall_wb}, 32'd1);
    checkOutput("starve_reg", {27'd0, bus.grf_reg}, 32'd9);
    applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_release", {31'd0, bus.stall_wb}, 32'd0);
    checkOutput("starve_wb_reg", {27'd0, bus.grf_reg}, 32'd3);

    // $0 slot drains a buffered MD write; MD write to $0 is consumed silently.
    applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 1, 5'd12, 32'hC0, 32'hC00, 0, 0);
    applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5'd0, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("slot_reg", {27'd0, bus.grf_reg}, 32'd12);
    checkOutput("slot_we", {31'd0, bus.grf_we}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0, 32'h77, 32'h700, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("md_r0_we", {31'd0, bus.grf_we}, 32'd0);

    // Full starvation window again (counter restarted), then reset in FORCE.
    applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 1, 5'd9, 32'h99, 32'h900, 1, 5'd9);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      applyStimulus(1, 1, 5'd3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
      checkOutput("restart_no_stall", {31'd0, bus.stall_wb}, 32'd0);
    end
    applyStimulus(0, 1, 5'd3, 32'h33, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("force_stall", {31'd0, bus.stall_wb}, 32'd1);
    checkOutput("force_busy9", {31'd0, bus.busy_mask[9]}, 32'd1);
    checkOutput("force_reset_we", {31'd0, bus.grf_we}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_stall", {31'd0, bus.stall_wb}, 32'd0);
    checkOutput("midrst_ready", {31'd0, bus.md_ready}, 32'd1);
    checkOutput("midrst_busy", bus.busy_mask, 32'd0);
    checkOutput("midrst_we", {31'd0, bus.grf_we}, 32'd0);

    // Randomised traffic with small register numbers to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                    $urandom, $urandom,
                    ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)),
                    $urandom, $urandom,
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
- Owns the single write port of the general register file (grf) and shares it between two requesters.
- Requester A is the pipeline writeback (WB) stage, which has fixed priority and never waits unless stalled.
- Requester B is the long-latency multiply/divide unit (MD). It writes through a one-entry buffer with valid/ready handshake.
- Also keeps a 32-bit busy scoreboard of registers with an MD result still outstanding (for the hazard unit), and forces a one-cycle WB stall when MD is starved.

Parameters:
- STARVE_LIMIT, 4, number of consecutive blocked cycles of a buffered MD write before WB is forcibly stalled (legal range 1..15).
- DATA_W, 32, data and PC width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- wb_we  in  1  WB write request.
- wb_reg  in  5  WB destination register.
- wb_data  in  DATA_W  WB write data.
- wb_pc  in  DATA_W  PC of the WB instruction.
- stall_wb  out  1  hold the WB stage; WB re-presents the same request next cycle.
- md_valid  in  1  MD result valid.
- md_ready  out  1  buffer can accept an MD result.
- md_reg  in  5  MD destination register.
- md_data  in  DATA_W  MD result.
- md_pc  in  DATA_W  PC of the MD instruction.
- md_issue  in  1  an MD instruction issued this cycle.
- md_issue_reg  in  5  destination register of the issued MD instruction.
- grf_we  out  1  to grf writeEnable.
- grf_reg  out  5  to grf writeReg.
- grf_data  out  DATA_W  to grf writeData.
- grf_pc  out  DATA_W  to grf PCReg.
- busy_mask  out  32  bit i = 1 means an MD write to $i is outstanding.

Behaviour:

State:
- FSM states: IDLE (buffer empty), PEND (buffer full, waiting), FORCE (buffer full, WB stalled).
- Buffer: buf_reg, buf_data, buf_pc.
- Wait counter wait_cnt, width clog2(STARVE_LIMIT+1).
- busy_mask.

Reset (reset==0 at a clk edge):
- state=IDLE, buffer invalid, wait_cnt=0, busy_mask=0.
- After the edge: md_ready=1, stall_wb=0.
- While reset==0, grf_we is forced 0 combinationally.

Handshake and timing:
- md_ready = (state==IDLE); registered, so there is no combinational path from md_valid.
- An MD transfer occurs on a clk edge where md_valid && md_ready; the buffer loads and state becomes PEND.
- Throughput is at most one MD write per 2 cycles.

Port free:
- port_free = !wb_we || wb_reg==0. A WB write to $0 never reaches the grf.

grf outputs (combinational from state and inputs):
- FORCE: drain the buffer; stall_wb=1; the WB request is ignored this cycle.
- PEND and port_free: drain the buffer.
- Otherwise: pass WB through; grf_we = wb_we && wb_reg!=0.
- Drain means grf_reg/data/pc = buf_*, grf_we = (buf_reg!=0). An MD write to $0 is consumed silently.

Transitions (clk edge, reset==1):
- IDLE -> PEND on an MD transfer; wait_cnt=0.
- PEND with port_free -> IDLE (drained); wait_cnt=0.
- PEND, blocked, wait_cnt==STARVE_LIMIT-1 -> FORCE.
- PEND, blocked, otherwise: stay in PEND; wait_cnt++.
- FORCE -> IDLE unconditionally; wait_cnt=0.
- stall_wb is Moore (state==FORCE) and lasts exactly 1 cycle.

Scoreboard:
- md_issue with md_issue_reg!=0 sets that bit at the edge.
- A drain clears bit buf_reg at the edge ending the drain cycle.
- Set and clear of the same bit in the same cycle: set wins.
- Setting an already-set bit leaves it set.
- WB writes never touch busy_mask.

Decomposition:
- Shared package grf_pkg: REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0, and the arbiter state enum (IDLE/PEND/FORCE).
- One natural sub-module: md_write_buffer (one-entry valid/ready holding register with load/drain).
- FSM, counter and scoreboard live in the top module.

Test Plan:
- Reset: hold reset=0 for 2 edges with wb_we=1, wb_reg=5 -> grf_we=0 throughout; afterwards busy_mask=0, md_ready=1, stall_wb=0.
- WB pass-through: wb_we=1, wb_reg=10, wb_data=16, wb_pc=0x12345678 -> same cycle grf_we=1, grf_reg=10, grf_data=16, grf_pc=0x12345678. Same with wb_reg=0 -> grf_we=0.
- MD on idle port: md_issue reg 8 in cycle N-1 -> busy_mask[8]=1. Then md_valid reg 8, data 0xDEADBEEF, pc 0x3000 with wb_we=0 in cycle N:
  - cycle N+1: grf_we=1, grf_reg=8, grf_data=0xDEADBEEF, md_ready=0.
  - cycle N+2: busy_mask[8]=0, md_ready=1.
- Starvation (STARVE_LIMIT=4): wb_we=1, wb_reg=3 every cycle; MD write to reg 9 accepted at edge N:
  - cycles N+1..N+4: grf_reg=3 (MD blocked).
  - cycle N+5: stall_wb=1, grf_reg=9.
  - cycle N+6: stall_wb=0, grf_reg=3.
- $0 slot: buffered MD reg 12 while WB presents wb_we=1, wb_reg=0 -> drained that cycle (grf_reg=12); wait_cnt returns to 0. MD write to reg 0 -> consumed with grf_we=0.
- Reset mid-operation: in FORCE with busy_mask[9]=1, drive reset=0 for one edge -> next cycle stall_wb=0, md_ready=1, busy_mask=0, no write to reg 9 afterwards.
